// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//   Streaming post-processor for natural-order FFT output bins. For every
//   frame it computes |X|^2 = I^2 + Q^2 per bin and, after the last bin,
//   strobes out the peak-power bin index, the peak power and the total
//   frame power. Frames that restart before FFT_LEN bins have arrived are
//   discarded and flagged.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for i_new_fft; samples without it are ignored
//   ACCUM | frame in progress; cnt is the index of the next expected bin
//
// Ports
//   clk          clock
//   i_init       asynchronous active-high reset
//   i_vld        input bin valid
//   i_new_fft    marks bin 0 of a frame (qualified by i_vld)
//   i_I, i_Q     signed bin real / imaginary parts
//   o_vld        one-cycle result strobe
//   o_peak_bin   index of the max-power bin (lowest index on ties)
//   o_peak_pwr   power of that bin
//   o_sum_pwr    sum of power over all bins of the frame
//   o_frame_err  one-cycle strobe on an aborted short frame
module fft_peak_detect #(
  parameter int IN_W    = 28,
  parameter int FFT_LEN = 256
) (
  input  logic                          clk,
  input  logic                          i_init,
  input  logic                          i_vld,
  input  logic                          i_new_fft,
  input  logic [IN_W-1:0]               i_I,
  input  logic [IN_W-1:0]               i_Q,
  output logic                          o_vld,
  output logic [$clog2(FFT_LEN)-1:0]    o_peak_bin,
  output logic [2*IN_W-1:0]             o_peak_pwr,
  output logic [2*IN_W+$clog2(FFT_LEN)-1:0] o_sum_pwr,
  output logic                          o_frame_err
);

  localparam int BIN_W = $clog2(FFT_LEN);
  localparam int PWR_W = 2 * IN_W;
  localparam int SUM_W = 2 * IN_W + BIN_W;
  localparam int SQ_W  = 2 * IN_W - 1;
  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FFT_LEN - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] cnt, cnt_nxt;

  logic             in_acc, in_first, in_last, short_err;
  logic [BIN_W-1:0] in_idx;

  // ---------------- input FSM: state register ----------------
  always_ff @(posedge clk or posedge i_init) begin
    if (i_init) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------- input FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (i_vld) begin
      if (i_new_fft) begin
        state_nxt = ACCUM;
        cnt_nxt   = BIN_W'(1);
      end else if (state == ACCUM) begin
        if (cnt == LAST_IDX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- input FSM: outputs (sample tags) ----------------
  always_comb begin
    in_acc    = i_vld && (i_new_fft || state == ACCUM);
    in_first  = i_vld && i_new_fft;
    in_last   = i_vld && !i_new_fft && state == ACCUM && cnt == LAST_IDX;
    in_idx    = i_new_fft ? '0 : cnt;
    // Any restart while in ACCUM means fewer than FFT_LEN bins arrived.
    short_err = i_vld && i_new_fft && state == ACCUM;
  end

  // ---------------- S1: register sample and tags ----------------
  logic             s1_vld, s1_first, s1_last;
  logic [BIN_W-1:0] s1_idx;
  logic [IN_W-1:0]  s1_i, s1_q;

  always_ff @(posedge clk or posedge i_init) begin
    if (i_init) begin
      s1_vld      <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_idx      <= '0;
      s1_i        <= '0;
      s1_q        <= '0;
      o_frame_err <= 1'b0;
    end else begin
      s1_vld      <= in_acc;
      s1_first    <= in_first;
      s1_last     <= in_last;
      s1_idx      <= in_idx;
      s1_i        <= i_I;
      s1_q        <= i_Q;
      o_frame_err <= short_err;
    end
  end

  // ---------------- S2: squares ----------------
  // Squaring the magnitude gives the same result as the signed square and
  // the IN_W-bit unsigned magnitude covers -2^(IN_W-1) exactly.
  logic [IN_W-1:0]  mag_i, mag_q;
  logic [SQ_W-1:0]  sq_i, sq_q;

  always_comb begin
    mag_i = s1_i[IN_W-1] ? (~s1_i + 1'b1) : s1_i;
    mag_q = s1_q[IN_W-1] ? (~s1_q + 1'b1) : s1_q;
    sq_i  = SQ_W'(mag_i) * SQ_W'(mag_i);
    sq_q  = SQ_W'(mag_q) * SQ_W'(mag_q);
  end

  logic             s2_vld, s2_first, s2_last;
  logic [BIN_W-1:0] s2_idx;
  logic [SQ_W-1:0]  s2_ii, s2_qq;

  always_ff @(posedge clk or posedge i_init) begin
    if (i_init) begin
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_idx   <= '0;
      s2_ii    <= '0;
      s2_qq    <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_idx   <= s1_idx;
      s2_ii    <= sq_i;
      s2_qq    <= sq_q;
    end
  end

  // ---------------- S3: power ----------------
  logic             s3_vld, s3_first, s3_last;
  logic [BIN_W-1:0] s3_idx;
  logic [PWR_W-1:0] s3_pwr;

  always_ff @(posedge clk or posedge i_init) begin
    if (i_init) begin
      s3_vld   <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
      s3_idx   <= '0;
      s3_pwr   <= '0;
    end else begin
      s3_vld   <= s2_vld;
      s3_first <= s2_first;
      s3_last  <= s2_last;
      s3_idx   <= s2_idx;
      s3_pwr   <= PWR_W'(s2_ii) + PWR_W'(s2_qq);
    end
  end

  // ---------------- S4: accumulate and report ----------------
  logic [PWR_W-1:0] best_pwr, best_pwr_nxt;
  logic [BIN_W-1:0] best_bin, best_bin_nxt;
  logic [SUM_W-1:0] acc, acc_nxt;

  always_comb begin
    best_pwr_nxt = best_pwr;
    best_bin_nxt = best_bin;
    acc_nxt      = acc + SUM_W'(s3_pwr);
    if (s3_first) begin
      best_pwr_nxt = s3_pwr;
      best_bin_nxt = s3_idx;
      acc_nxt      = SUM_W'(s3_pwr);
    end else if (s3_pwr > best_pwr) begin
      best_pwr_nxt = s3_pwr;
      best_bin_nxt = s3_idx;
    end
  end

  // Result registers are separate from the running ones so they hold while
  // the next frame accumulates.
  always_ff @(posedge clk or posedge i_init) begin
    if (i_init) begin
      best_pwr   <= '0;
      best_bin   <= '0;
      acc        <= '0;
      o_vld      <= 1'b0;
      o_peak_bin <= '0;
      o_peak_pwr <= '0;
      o_sum_pwr  <= '0;
    end else begin
      o_vld <= s3_vld && s3_last;
      if (s3_vld) begin
        best_pwr <= best_pwr_nxt;
        best_bin <= best_bin_nxt;
        acc      <= acc_nxt;
        if (s3_last) begin
          o_peak_bin <= best_bin_nxt;
          o_peak_pwr <= best_pwr_nxt;
          o_sum_pwr  <= acc_nxt;
        end
      end
    end
  end

endmodule
